// File: rtl/int_pkg.sv
// Shared definitions for the vectored interrupt controller.
//   NUM_IRQ        : number of interrupt lines
//   DEF_VEC_BASE   : default vector address of IRQ0
//   DEF_VEC_STRIDE : default spacing between consecutive vectors
//   state_t        : controller state encoding
//   vec_addr()     : vector address for an interrupt id (wraps mod 256)
package int_pkg;

  localparam int NUM_IRQ = 4;
  localparam logic [7:0] DEF_VEC_BASE = 8'hF0;
  localparam int DEF_VEC_STRIDE = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2,
    EXIT    = 2'd3
  } state_t;

  function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                          input int         stride,
                                          input logic [1:0] id);
    logic [7:0] stride8;
    stride8 = 8'(stride);
    return base + stride8 * {6'd0, id};
  endfunction

endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-to-2 priority encoder, bit 0 has highest priority.
//   req   in  4  request vector
//   id    out 2  index of the highest-priority set bit (0 when none)
//   valid out 1  at least one request bit is set
module prio_enc4 (
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       valid
);

  always_comb begin
    id    = 2'd0;
    valid = |req;
    if (req[0])      id = 2'd0;
    else if (req[1]) id = 2'd1;
    else if (req[2]) id = 2'd2;
    else if (req[3]) id = 2'd3;
  end

endmodule

// File: rtl/int_ctrl.sv
// Single-level vectored interrupt controller.
// Latches rising edges on four irq lines, accepts the highest-priority
// enabled request at an instruction boundary, jumps to its vector and
// restores the saved PC/flags on return-from-interrupt.
//   Clk, Rst        clock, async active-high reset
//   irq             interrupt lines (rising edge requests)
//   instr_boundary  PC is about to advance to a new instruction
//   pc_in, band_in  context captured on acceptance
//   ei, di, reti    decoder strobes
//   mask_we/wdata   mask register write (1 = enabled)
//   pc_load, pc_load_addr        PC load strobe and address
//   band_restore, band_out       flag restore strobe and value
//   in_service      one-hot id of the interrupt being serviced
//   gie             global interrupt enable
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for an enabled request at a boundary
// ENTER   | one cycle: load PC with the vector address
// SERVICE | handler running, waiting for reti
// EXIT    | one cycle: load PC with return address, restore flags
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [7:0] VEC_BASE   = DEF_VEC_BASE,
  parameter int         VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [3:0] irq,
  input  logic       instr_boundary,
  input  logic [7:0] pc_in,
  input  logic [2:0] band_in,
  input  logic       ei,
  input  logic       di,
  input  logic       reti,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  output logic       pc_load,
  output logic [7:0] pc_load_addr,
  output logic       band_restore,
  output logic [2:0] band_out,
  output logic [3:0] in_service,
  output logic       gie
);

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] req_en;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [7:0]         ret_addr;
  logic [2:0]         ret_band;
  logic [1:0]         enc_id;
  logic               enc_valid;
  logic               accept;
  logic               leave;

  assign req_en = pending & mask;
  assign rise   = irq & ~irq_q;
  assign clr    = accept ? (4'b0001 << enc_id) : 4'b0000;

  prio_enc4 u_prio_enc4 (
    .req   (req_en),
    .id    (enc_id),
    .valid (enc_valid)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    leave   = 1'b0;
    case (state_q)
      IDLE: begin
        if (gie && enc_valid && instr_boundary) begin
          accept  = 1'b1;
          state_d = ENTER;
        end
      end
      ENTER:   state_d = SERVICE;
      SERVICE: begin
        if (reti) begin
          leave   = 1'b1;
          state_d = EXIT;
        end
      end
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the one-cycle states; the address and flag
  // outputs are registers loaded on the way in, so they hold afterwards.
  assign pc_load      = (state_q == ENTER) || (state_q == EXIT);
  assign band_restore = (state_q == EXIT);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      irq_q        <= '0;
      pending      <= '0;
      mask         <= '0;
      gie          <= 1'b0;
      ret_addr     <= 8'h00;
      ret_band     <= 3'b000;
      pc_load_addr <= 8'h00;
      band_out     <= 3'b000;
      in_service   <= 4'b0000;
    end else begin
      irq_q <= irq;
      // A new edge wins over the acceptance clear so it is never lost.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;

      if (state_q == EXIT) gie <= 1'b1;
      else if (accept)     gie <= 1'b0;
      else if (di)         gie <= 1'b0;
      else if (ei)         gie <= 1'b1;

      if (accept) begin
        ret_addr     <= pc_in;
        ret_band     <= band_in;
        pc_load_addr <= vec_addr(VEC_BASE, VEC_STRIDE, enc_id);
        in_service   <= 4'b0001 << enc_id;
      end
      if (leave) begin
        pc_load_addr <= ret_addr;
        band_out     <= ret_band;
      end
      if (state_q == EXIT) in_service <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
module tb_int_ctrl;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [3:0] irq = '0;
  logic       instr_boundary = 1'b0;
  logic [7:0] pc_in = '0;
  logic [2:0] band_in = '0;
  logic       ei = 1'b0, di = 1'b0, reti = 1'b0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       pc_load, band_restore, gie;
  logic [7:0] pc_load_addr;
  logic [2:0] band_out;
  logic [3:0] in_service;

  int_ctrl dut (
    .Clk(Clk), .Rst(Rst), .irq(irq), .instr_boundary(instr_boundary),
    .pc_in(pc_in), .band_in(band_in), .ei(ei), .di(di), .reti(reti),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .pc_load(pc_load),
    .pc_load_addr(pc_load_addr), .band_restore(band_restore),
    .band_out(band_out), .in_service(in_service), .gie(gie)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] addr;
    logic       is_exit;
    logic [2:0] band;
    logic [3:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int strobes = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic x, input logic [2:0] b, input logic [3:0] s);
    exp_t e;
    e.addr = a; e.is_exit = x; e.band = b; e.ins = s;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe cycle is matched against the next expected event.
  always @(negedge Clk) begin
    if (pc_load || band_restore) begin
      exp_t e;
      strobes++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_strobe: pc_load=%0b addr=%0h band_restore=%0b, none expected",
                 pc_load, pc_load_addr, band_restore);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_pc_load", {7'd0, pc_load}, 8'd1);
        chk("strobe_addr", pc_load_addr, e.addr);
        chk("strobe_band_restore", {7'd0, band_restore}, {7'd0, e.is_exit});
        if (e.is_exit) chk("exit_band_out", {5'd0, band_out}, {5'd0, e.band});
        else begin
          chk("enter_in_service", {4'd0, in_service}, {4'd0, e.ins});
          chk("enter_gie", {7'd0, gie}, 8'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, simulation still running");
    $fatal(1, "watchdog");
  end

  task automatic do_reti();
    reti = 1'b1; tick(); reti = 1'b0; tick();
  endtask

  initial begin
    int s0;
    tick(); tick();
    Rst = 1'b0;
    tick();
    chk("rst_pc_load", {7'd0, pc_load}, 8'd0);
    chk("rst_addr", pc_load_addr, 8'h00);
    chk("rst_band_restore", {7'd0, band_restore}, 8'd0);
    chk("rst_band_out", {5'd0, band_out}, 8'd0);
    chk("rst_in_service", {4'd0, in_service}, 8'd0);
    chk("rst_gie", {7'd0, gie}, 8'd0);

    // 1: irq2 -> vector F8, then return to 23 with flags 101
    mask_we = 1'b1; mask_wdata = 4'hF; ei = 1'b1; tick();
    mask_we = 1'b0; ei = 1'b0;
    chk("t1_gie_set", {7'd0, gie}, 8'd1);
    instr_boundary = 1'b1; pc_in = 8'h23; band_in = 3'b101;
    push(8'hF8, 1'b0, 3'b000, 4'b0100);
    irq = 4'b0100; tick(); irq = 4'b0000; tick();
    chk("t1_enter_ins", {4'd0, in_service}, 8'h04);
    tick(); tick();
    push(8'h23, 1'b1, 3'b101, 4'b0000);
    do_reti();
    chk("t1_ins_clr", {4'd0, in_service}, 8'h00);
    chk("t1_gie_back", {7'd0, gie}, 8'd1);
    chk("t1_addr_hold", pc_load_addr, 8'h23);
    chk("t1_band_hold", {5'd0, band_out}, 8'h05);
    chk("t1_strobes", strobes[7:0], 8'd2);

    // 2: irq1 and irq3 together -> F4 first, then FC after exit
    pc_in = 8'h40; band_in = 3'b010;
    push(8'hF4, 1'b0, 3'b000, 4'b0010);
    irq = 4'b1010; tick(); irq = 4'b0000; tick();
    chk("t2_first_ins", {4'd0, in_service}, 8'h02);
    tick(); tick();
    push(8'h40, 1'b1, 3'b010, 4'b0000);
    push(8'hFC, 1'b0, 3'b000, 4'b1000);
    do_reti();
    tick();
    chk("t2_second_ins", {4'd0, in_service}, 8'h08);
    tick();
    push(8'h40, 1'b1, 3'b010, 4'b0000);
    do_reti();
    chk("t2_strobes", strobes[7:0], 8'd6);

    // 3: masked irq0 is held until the mask opens
    pc_in = 8'h55; band_in = 3'b111;
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
    irq = 4'b0001; tick(); irq = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_masked_no_strobe", strobes[7:0], 8'd6);
    push(8'hF0, 1'b0, 3'b000, 4'b0001);
    mask_we = 1'b1; mask_wdata = 4'hF; tick(); mask_we = 1'b0;
    tick();
    chk("t3_ins", {4'd0, in_service}, 8'h01);
    tick();
    push(8'h55, 1'b1, 3'b111, 4'b0000);
    do_reti();

    // 4: no boundary -> no acceptance
    instr_boundary = 1'b0; pc_in = 8'h66; band_in = 3'b001;
    irq = 4'b0100; tick(); irq = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_no_boundary", strobes[7:0], 8'd8);
    push(8'hF8, 1'b0, 3'b000, 4'b0100);
    instr_boundary = 1'b1; tick();
    chk("t4_ins", {4'd0, in_service}, 8'h04);
    tick();
    push(8'h66, 1'b1, 3'b001, 4'b0000);
    do_reti();

    // 5: ei+di -> di wins; reti in IDLE ignored; set beats clear
    ei = 1'b1; di = 1'b1; tick(); ei = 1'b0; di = 1'b0;
    chk("t5_di_wins", {7'd0, gie}, 8'd0);
    do_reti();
    chk("t5_reti_idle", strobes[7:0], 8'd10);
    ei = 1'b1; tick(); ei = 1'b0;
    chk("t5_ei", {7'd0, gie}, 8'd1);
    instr_boundary = 1'b0; pc_in = 8'h77; band_in = 3'b011;
    irq = 4'b0001; tick(); irq = 4'b0000; tick();
    push(8'hF0, 1'b0, 3'b000, 4'b0001);
    irq = 4'b0001; instr_boundary = 1'b1; tick();
    irq = 4'b0000; tick();
    push(8'h77, 1'b1, 3'b011, 4'b0000);
    push(8'hF0, 1'b0, 3'b000, 4'b0001);
    do_reti();
    tick();
    chk("t5_reaccept_ins", {4'd0, in_service}, 8'h01);
    tick();

    // 6: reset during SERVICE
    Rst = 1'b1; #2;
    chk("t6_ins", {4'd0, in_service}, 8'h00);
    chk("t6_gie", {7'd0, gie}, 8'd0);
    chk("t6_addr", pc_load_addr, 8'h00);
    tick(); Rst = 1'b0;
    s0 = strobes;
    ei = 1'b1; tick(); ei = 1'b0;
    irq = 4'b0010; tick(); irq = 4'b0000;
    tick(); tick();
    do_reti();
    tick(); tick();
    chk("t6_masked_after_rst", strobes[7:0], s0[7:0]);
    chk("t6_gie_after", {7'd0, gie}, 8'd1);

    chk("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Single-level vectored interrupt controller for the 8-bit microprocessor.
- Latches 4 interrupt lines and selects the highest-priority enabled request.
- At an instruction boundary, forces the program counter to a vector address and saves the return address and the 3-bit flag register.
- On return-from-interrupt, restores the saved PC and flags.
- Sits beside the control unit and drives the PC-load and flag-restore inputs of the jump/flag logic.

Parameters:
VEC_BASE, 8'hF0, vector address of IRQ0.
VEC_STRIDE, 4, address spacing between consecutive vectors (vector = VEC_BASE + id*VEC_STRIDE, mod 256).

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-high reset.
irq  in  4  interrupt lines, synchronous to Clk; rising edge requests; bit 0 has highest priority.
instr_boundary  in  1  high in the cycle the PC would advance to a new instruction.
pc_in  in  8  current instruction address (Address_Instruction_Bus).
band_in  in  3  current flag register value.
ei  in  1  enable-interrupts strobe from the decoder.
di  in  1  disable-interrupts strobe.
reti  in  1  return-from-interrupt strobe.
mask_we  in  1  mask register write strobe.
mask_wdata  in  4  new mask value; 1 = enabled.
pc_load  out  1  one-cycle strobe: load PC from pc_load_addr.
pc_load_addr  out  8  vector or return address.
band_restore  out  1  one-cycle strobe: load flags from band_out.
band_out  out  3  saved flags.
in_service  out  4  one-hot ID of the interrupt being serviced; 0 when idle.
gie  out  1  global interrupt enable.

Behaviour:
Reset values (asynchronous):
- state = IDLE.
- All outputs 0, including pc_load_addr = 8'h00.
- pending = 0, mask = 0 (all masked), irq_q = 0, ret_addr = 0, ret_band = 0.

Edge detection and pending:
- irq_q <= irq each cycle.
- pending[i] sets on irq[i] & ~irq_q[i].
- pending[i] clears when IRQ i is accepted.
- Set and clear in the same cycle: set wins (a new edge is never lost).
- A pending bit whose mask bit is 0 is held, not dropped.

Mask and global enable:
- mask <= mask_wdata when mask_we; the write takes effect on the next cycle's arbitration.
- gie: ei sets it, di clears it; ei and di together: di wins.
- Entering ENTER clears gie; EXIT sets gie. These override ei/di in the same cycle.

States:
- IDLE: if gie & |(pending & mask) & instr_boundary, then:
  - id <= priority-encode(pending & mask);
  - ret_addr <= pc_in; ret_band <= band_in;
  - clear pending[id]; go to ENTER.
  - Otherwise stay in IDLE. reti in IDLE is ignored (no strobes).
- ENTER (1 cycle):
  - pc_load = 1, pc_load_addr = VEC_BASE + id*VEC_STRIDE.
  - in_service = 1<<id; go to SERVICE.
- SERVICE:
  - in_service held.
  - New requests only set pending; no nesting.
  - ei/di update gie, but acceptance happens only in IDLE.
  - reti -> EXIT.
- EXIT (1 cycle):
  - pc_load = 1, pc_load_addr = ret_addr; band_restore = 1, band_out = ret_band.
  - gie <= 1, in_service <= 0; go to IDLE.

Latency:
- irq edge sampled at clock edge N -> pending visible at N+1.
- With an instruction boundary at N+1, pc_load is asserted during cycle N+2.
- A back-to-back pending interrupt is re-accepted no earlier than the first boundary after EXIT.

Outside ENTER and EXIT:
- pc_load = 0 and band_restore = 0.
- pc_load_addr and band_out hold their last values.

Rst asserted mid-service: immediate return to reset values; the saved context is discarded.

Decomposition:
- Package int_pkg holds:
  - state encoding (IDLE, ENTER, SERVICE, EXIT, 2 bits);
  - NUM_IRQ = 4;
  - default VEC_BASE and VEC_STRIDE.
- Sub-module prio_enc4: combinational 4-to-2 priority encoder with a valid output, bit 0 highest priority.

Test Plan:
1. Reset, then mask_we with 4'b1111, ei; pulse irq[2] with pc_in = 8'h23, band_in = 3'b101, boundary held high -> pc_load with addr 8'hF8, in_service = 4'b0100, gie = 0; then reti -> pc_load with addr 8'h23, band_restore with band_out = 3'b101, gie = 1.
2. irq[1] and irq[3] rise in the same cycle, everything enabled -> vector 8'hF4 serviced first; after reti and the next boundary -> vector 8'hFC.
3. Mask = 4'b1110, pulse irq[0] -> no pc_load; then write mask = 4'b1111 -> irq 0 accepted, pc_load_addr = 8'hF0 (the request was held).
4. instr_boundary low for 5 cycles with a request pending -> no pc_load; boundary rises -> pc_load on the following cycle.
5. ei and di in the same cycle -> gie = 0. reti in IDLE -> no strobes. A new irq[0] edge in the same cycle IRQ 0 is accepted -> pending[0] remains 1.
6. Assert Rst during SERVICE -> in_service = 0, gie = 0, mask = 0 immediately; a later reti produces no strobes.
